// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with operand forwarding and load-use stall
module id_ex_operand_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [REG_AW-1:0] id_rw,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [3:0]        id_op,
  input  logic [DATA_W-1:0] bus_a,
  input  logic [DATA_W-1:0] bus_b,
  input  logic [REG_AW-1:0] mem_rw,
  input  logic              mem_reg_write,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [REG_AW-1:0] wb_rw,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [3:0]        ex_op,
  output logic [REG_AW-1:0] ex_rw,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [3:0]        op_q, op_d;
  logic [REG_AW-1:0] rw_q, rw_d;
  logic              wr_q, wr_d, mr_q, mr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic              hz;

  // EX/MEM is the younger producer, so it wins over MEM/WB; R0 is hardwired zero
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_AW-1:0] src,
    input logic [DATA_W-1:0] bus,
    input logic              m_we,
    input logic [REG_AW-1:0] m_rw,
    input logic [DATA_W-1:0] m_val,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rw,
    input logic [DATA_W-1:0] w_val
  );
    if (src == '0)                  return '0;
    else if (m_we && (m_rw == src)) return m_val;
    else if (w_we && (w_rw == src)) return w_val;
    else                            return bus;
  endfunction

  always_comb begin
    fwd_a = resolve(id_ra, bus_a, mem_reg_write, mem_rw, mem_result,
                    wb_reg_write, wb_rw, wb_data);
    fwd_b = resolve(id_rb, bus_b, mem_reg_write, mem_rw, mem_result,
                    wb_reg_write, wb_rw, wb_data);
  end

  assign hz = id_valid && valid_q && mr_q && (rw_q != '0) &&
              ((id_use_a && (id_ra == rw_q)) || (id_use_b && (id_rb == rw_q)));
  assign stall = hz && !flush;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    op_d    = op_q;
    rw_d    = rw_q;
    wr_d    = wr_q;
    mr_d    = mr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      wr_d    = 1'b0;
      mr_d    = 1'b0;
    end else if (stall) begin
      valid_d = 1'b0;
      wr_d    = 1'b0;
      mr_d    = 1'b0;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else begin
      valid_d = id_valid;
      a_d     = fwd_a;
      b_d     = fwd_b;
      imm_d   = id_imm;
      op_d    = id_op;
      rw_d    = id_rw;
      wr_d    = id_reg_write && id_valid;
      mr_d    = id_mem_read && id_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      op_q    <= '0;
      rw_q    <= '0;
      wr_q    <= 1'b0;
      mr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      op_q    <= op_d;
      rw_q    <= rw_d;
      wr_q    <= wr_d;
      mr_q    <= mr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_a         = a_q;
  assign ex_b         = b_q;
  assign ex_imm       = imm_q;
  assign ex_op        = op_q;
  assign ex_rw        = rw_q;
  assign ex_reg_write = wr_q;
  assign ex_mem_read  = mr_q;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - randomized self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              id_valid, id_use_a, id_use_b, id_reg_write, id_mem_read;
  logic [REG_AW-1:0] id_ra, id_rb, id_rw, mem_rw, wb_rw;
  logic [DATA_W-1:0] id_imm, bus_a, bus_b, mem_result, wb_data;
  logic [3:0]        id_op;
  logic              mem_reg_write, wb_reg_write, flush;
  logic              stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [DATA_W-1:0] ex_a, ex_b, ex_imm;
  logic [3:0]        ex_op;
  logic [REG_AW-1:0] ex_rw;
  logic [CNT_W-1:0]  stall_count;

  id_ex_operand_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ra(id_ra), .id_rb(id_rb),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_rw(id_rw), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_imm(id_imm), .id_op(id_op), .bus_a(bus_a), .bus_b(bus_b),
    .mem_rw(mem_rw), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rw(wb_rw), .wb_reg_write(wb_reg_write), .wb_data(wb_data), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
    .ex_op(ex_op), .ex_rw(ex_rw), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .stall_count(stall_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the EX slot should hold after each edge
  logic              m_valid, m_wr, m_mr;
  logic [DATA_W-1:0] m_a, m_b, m_imm;
  logic [3:0]        m_op;
  logic [REG_AW-1:0] m_rw;
  int                m_cnt;
  logic [DATA_W-1:0] rf [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] resolve(input logic [REG_AW-1:0] src,
                                                input logic [DATA_W-1:0] bus_val);
    if (src == 0) return 0;
    if (mem_reg_write && mem_rw == src) return mem_result;
    if (wb_reg_write && wb_rw == src) return wb_data;
    return bus_val;
  endfunction

  function automatic logic model_stall();
    logic reads_load;
    reads_load = (id_use_a && id_ra == m_rw) || (id_use_b && id_rb == m_rw);
    return id_valid && m_valid && m_mr && (m_rw != 0) && reads_load && !flush;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wr = 0; m_mr = 0; m_a = 0; m_b = 0; m_imm = 0; m_op = 0; m_rw = 0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 32'(ex_valid), 32'(m_valid));
    check({tag, "_wr"}, 32'(ex_reg_write), 32'(m_wr));
    check({tag, "_mr"}, 32'(ex_mem_read), 32'(m_mr));
    check({tag, "_cnt"}, 32'(stall_count), 32'(m_cnt));
    if (m_valid) begin
      check({tag, "_a"}, 32'(ex_a), 32'(m_a));
      check({tag, "_b"}, 32'(ex_b), 32'(m_b));
      check({tag, "_imm"}, 32'(ex_imm), 32'(m_imm));
      check({tag, "_op"}, 32'(ex_op), 32'(m_op));
      check({tag, "_rw"}, 32'(ex_rw), 32'(m_rw));
    end
  endtask

  task automatic idle();
    id_valid = 0; id_use_a = 0; id_use_b = 0; id_reg_write = 0; id_mem_read = 0;
    id_ra = 0; id_rb = 0; id_rw = 0; id_imm = 0; id_op = 0; bus_a = 0; bus_b = 0;
    mem_rw = 0; mem_reg_write = 0; mem_result = 0;
    wb_rw = 0; wb_reg_write = 0; wb_data = 0; flush = 0;
  endtask

  task automatic step(input string tag);
    logic exp_stall;
    #1;
    exp_stall = model_stall();
    check({tag, "_stall"}, 32'(stall), 32'(exp_stall));
    if (flush || exp_stall) begin
      m_valid = 0; m_wr = 0; m_mr = 0;
      if (!flush && m_cnt < CMAX) m_cnt++;
    end else begin
      m_valid = id_valid;
      m_a     = resolve(id_ra, bus_a);
      m_b     = resolve(id_rb, bus_b);
      m_imm   = id_imm;
      m_op    = id_op;
      m_rw    = id_rw;
      m_wr    = id_reg_write && id_valid;
      m_mr    = id_mem_read && id_valid;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic issue_load(input logic [REG_AW-1:0] rd);
    idle();
    id_valid = 1; id_rw = rd; id_reg_write = 1; id_mem_read = 1; id_op = 4'h8;
    step("ld");
  endtask

  initial begin
    idle();
    model_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst");
    check("rst_stall", 32'(stall), 0);
    @(negedge clk) reset = 0;

    id_valid = 1; id_ra = 1; bus_a = 16'h0002; id_rb = 2; bus_b = 16'h0003;
    id_use_a = 1; id_use_b = 1; id_rw = 3; id_reg_write = 1; id_imm = 16'h0042; id_op = 4'h1;
    step("nohaz");
    check("nohaz_a_const", 32'(ex_a), 32'h0002);
    check("nohaz_b_const", 32'(ex_b), 32'h0003);
    check("nohaz_v_const", 32'(ex_valid), 1);

    idle();
    id_valid = 1; id_ra = 4; id_use_a = 1; bus_a = 16'h5555;
    mem_rw = 4; mem_reg_write = 1; mem_result = 16'h1111;
    wb_rw = 4; wb_reg_write = 1; wb_data = 16'h2222;
    step("prio_mem");
    check("prio_mem_const", 32'(ex_a), 32'h1111);
    mem_reg_write = 0;
    step("prio_wb");
    check("prio_wb_const", 32'(ex_a), 32'h2222);

    idle();
    id_valid = 1; id_rb = 0; id_use_b = 1; bus_b = 16'h1234;
    mem_rw = 0; mem_reg_write = 1; mem_result = 16'hFFFF;
    step("r0");
    check("r0_const", 32'(ex_b), 32'h0000);

    issue_load(5);
    idle();
    id_valid = 1; id_ra = 5; id_use_a = 1; bus_a = 16'h0BAD; id_op = 4'h2;
    step("lu_stall");
    check("lu_bubble", 32'(ex_valid), 0);
    check("lu_cnt_const", 32'(stall_count), 1);
    wb_rw = 5; wb_reg_write = 1; wb_data = 16'hBEEF;
    step("lu_go");
    check("lu_fwd_const", 32'(ex_a), 32'hBEEF);
    check("lu_nostall", 32'(stall), 0);

    issue_load(5);
    idle();
    id_valid = 1; id_ra = 5; id_use_a = 1; flush = 1;
    step("flush");
    check("flush_cnt_const", 32'(stall_count), 1);

    issue_load(5);
    idle();
    id_valid = 1; id_rb = 5; id_use_b = 1;
    #1;
    check("mid_stall_pre", 32'(stall), 1);
    reset = 1;
    #1;
    model_reset();
    check_outputs("arst");
    check("arst_stall", 32'(stall), 0);
    @(negedge clk) reset = 0;

    for (int i = 0; i < CMAX + 3; i++) begin
      issue_load(3'(1 + (i % 7)));
      idle();
      id_valid = 1; id_rb = 3'(1 + (i % 7)); id_use_b = 1;
      step("sat");
    end
    check("sat_const", 32'(stall_count), CMAX);

    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    for (int i = 0; i < 400; i++) begin
      id_valid     = ($urandom % 5) != 0;
      id_ra        = ($urandom % 2) ? m_rw : 3'($urandom);
      id_rb        = ($urandom % 2) ? m_rw : 3'($urandom);
      id_use_a     = 1'($urandom);
      id_use_b     = 1'($urandom);
      id_rw        = 3'($urandom);
      id_reg_write = 1'($urandom);
      id_mem_read  = ($urandom % 3) == 0;
      id_imm       = 16'($urandom);
      id_op        = 4'($urandom);
      bus_a        = rf[id_ra];
      bus_b        = rf[id_rb];
      mem_rw       = 3'($urandom);
      mem_reg_write = 1'($urandom);
      mem_result   = 16'($urandom);
      wb_rw        = 3'($urandom);
      wb_reg_write = 1'($urandom);
      wb_data      = 16'($urandom);
      flush        = ($urandom % 8) == 0;
      step("rnd");
      if (wb_reg_write && wb_rw != 0) rf[wb_rw] = wb_data;
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- Decode-to-execute pipeline stage sitting directly downstream of the 8x16 register file.
- Captures the decoded instruction fields and the register-file read buses (BusA/BusB), and applies operand forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards, stalling decode and inserting a bubble.
- Registers the resolved operands into the ID/EX pipeline register consumed by the ALU.

Parameters:
- DATA_W, 16, operand/result width
- REG_AW, 3, register address width (8 registers, R0 reads as zero and is never written)
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  input  1  pipeline clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- id_valid  input  1  decode slot holds a real instruction
- id_ra  input  REG_AW  source register A (drives the register file's RA)
- id_rb  input  REG_AW  source register B (drives the register file's RB)
- id_use_a  input  1  instruction reads ra
- id_use_b  input  1  instruction reads rb
- id_rw  input  REG_AW  destination register
- id_reg_write  input  1  instruction writes rw
- id_mem_read  input  1  instruction is a load
- id_imm  input  DATA_W  sign-extended immediate
- id_op  input  4  ALU/control opcode
- bus_a  input  DATA_W  register-file read data A
- bus_b  input  DATA_W  register-file read data B
- mem_rw  input  REG_AW  EX/MEM destination register
- mem_reg_write  input  1  EX/MEM writes a register
- mem_result  input  DATA_W  EX/MEM ALU result
- wb_rw  input  REG_AW  MEM/WB destination register
- wb_reg_write  input  1  MEM/WB writes a register
- wb_data  input  DATA_W  MEM/WB write-back data (same value as the register file's BusW)
- flush  input  1  branch/jump redirect; kill the decode slot
- stall  output  1  hold PC and IF/ID (combinational)
- ex_valid  output  1  EX slot valid
- ex_a  output  DATA_W  resolved operand A
- ex_b  output  DATA_W  resolved operand B
- ex_imm  output  DATA_W  registered immediate
- ex_op  output  4  registered opcode
- ex_rw  output  REG_AW  registered destination
- ex_reg_write  output  1  registered write enable (0 when ex_valid=0)
- ex_mem_read  output  1  registered load flag (0 when ex_valid=0)
- stall_count  output  CNT_W  number of load-use stall cycles

Behaviour:
- Reset (asynchronous, active-high): ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_a=ex_b=ex_imm=0, ex_op=0, ex_rw=0, stall_count=0. Reset takes effect immediately, even mid-stall. The first rising edge after reset deasserts accepts the decode slot normally.
- Forwarding, per operand X in {a,b}, with src=id_ra or id_rb, evaluated combinationally with priority top-down:
  1. src==0: value is 0; R0 is never forwarded.
  2. mem_reg_write && mem_rw==src: value is mem_result.
  3. wb_reg_write && wb_rw==src: value is wb_data. This covers the register file's write-after-read-edge timing.
  4. Otherwise: value is bus_X.
- Load-use hazard: hz = id_valid && ex_valid && ex_mem_read && ex_rw!=0 && ((id_use_a && id_ra==ex_rw) || (id_use_b && id_rb==ex_rw)).
- stall = hz && !flush.
- Rising edge, priority order:
  - flush: ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0; data fields don't-care, held.
  - else stall: bubble (ex_valid<=0, ex_reg_write<=0, ex_mem_read<=0); stall_count increments.
  - else: ex_valid<=id_valid; ex_a/ex_b<=forwarded values; ex_imm, ex_op, ex_rw<=decode fields; ex_reg_write<=id_reg_write&&id_valid; ex_mem_read<=id_mem_read&&id_valid.
- Stall length: one cycle only. In the next cycle the load sits in EX/MEM and is no longer in EX, so hz drops and the loaded value forwards from the MEM/WB path on the following cycle.
- id_valid=0 never raises stall and loads a bubble.
- stall_count saturates at 2^CNT_W-1 and does not wrap.
- Latency: one cycle from decode inputs to ex_* outputs.

Test Plan:
- Reset asserted mid-stall (ex_mem_read=1, hz=1) -> all ex_* outputs and stall_count become 0 immediately, asynchronously; stall=0.
- No hazard: id_ra=1 (bus_a=0x0002), id_rb=2 (bus_b=0x0003), no forwarding -> next edge ex_a=0x0002, ex_b=0x0003, ex_valid=1.
- Priority: id_ra=4 with mem_rw=4 (mem_result=0x1111) and wb_rw=4 (wb_data=0x2222), both writing -> ex_a=0x1111. Drop mem_reg_write -> ex_a=0x2222.
- R0: id_rb=0, mem_rw=0, mem_reg_write=1, mem_result=0xFFFF -> ex_b=0x0000.
- Load-use: EX holds a load with rw=5; decode reads ra=5 -> stall=1 for exactly one cycle, bubble ex_valid=0, stall_count=1. The following cycle accepts the instruction with wb_data forwarded.
- Flush during hazard: flush=1 with hz=1 -> stall=0, ex_valid=0, stall_count unchanged.
